range_finder_stream: RTL and testbench



---
 rtl/range_finder_stream.sv | 183 ++++++++++++++++++
 tb/tb_range_finder_stream.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/range_finder_stream.sv
// range_finder_stream
//   Streaming min/max/range tracker. Samples are framed by go/finish and
//   qualified by valid. On a successful finish the minimum, maximum,
//   range (max - min at WIDTH+1 bits) and saturating sample count of the
//   sequence are published and done pulses for one cycle. Framing errors
//   (finish outside a sequence, go inside a sequence, empty sequence)
//   park the block in a sticky ERROR state left only by go & ~finish.
//
//   Build option: define RANGE_FINDER_SIGNED_EN to treat data_in as two's
//   complement (signed compares, sign-extended range). Default: unsigned.
//
// Ports
//   clock      in   rising-edge clock
//   reset      in   synchronous active-high reset
//   data_in    in   [WIDTH]      sample
//   valid      in   sample qualifier
//   go         in   start a sequence
//   finish     in   end the sequence (this cycle's valid sample included)
//   min_val    out  [WIDTH]      minimum of last completed sequence
//   max_val    out  [WIDTH]      maximum of last completed sequence
//   range      out  [WIDTH+1]    max_val - min_val
//   count      out  [CNT_WIDTH]  valid samples (saturating)
//   count_sat  out  count saturated in last completed sequence
//   done       out  one-cycle completion pulse
//   busy       out  high while in RUN
//   error      out  high while in ERROR
module range_finder_stream #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     data_in,
  input  logic                 valid,
  input  logic                 go,
  input  logic                 finish,
  output logic [WIDTH-1:0]     min_val,
  output logic [WIDTH-1:0]     max_val,
  output logic [WIDTH:0]       range,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 count_sat,
  output logic                 done,
  output logic                 busy,
  output logic                 error
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_ERROR = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t               state, state_next;
  logic [WIDTH-1:0]     cur_min, cur_max;
  logic [CNT_WIDTH-1:0] cur_cnt;
  logic                 cur_sat;

  logic                 clear_work;
  logic                 take;
  logic                 complete;

  logic [WIDTH-1:0]     base_min, base_max;
  logic [CNT_WIDTH-1:0] base_cnt;
  logic                 base_sat;
  logic [WIDTH-1:0]     nxt_min, nxt_max;
  logic [CNT_WIDTH-1:0] nxt_cnt;
  logic                 nxt_sat;
  logic [WIDTH:0]       nxt_range;

  function automatic logic is_less(input logic [WIDTH-1:0] a,
                                   input logic [WIDTH-1:0] b);
`ifdef RANGE_FINDER_SIGNED_EN
    return $signed(a) < $signed(b);
`else
    return a < b;
`endif
  endfunction

  function automatic logic [WIDTH:0] extend(input logic [WIDTH-1:0] x);
`ifdef RANGE_FINDER_SIGNED_EN
    return {x[WIDTH-1], x};
`else
    return {1'b0, x};
`endif
  endfunction

  // Framing decisions.
  always_comb begin
    state_next = state;
    clear_work = 1'b0;
    take       = 1'b0;
    complete   = 1'b0;
    case (state)
      ST_RUN: begin
        if (go) begin
          state_next = ST_ERROR;
        end else if (finish) begin
          take = valid;
          if (nxt_cnt == '0) begin
            state_next = ST_ERROR;
          end else begin
            complete   = 1'b1;
            state_next = ST_IDLE;
          end
        end else begin
          take = valid;
        end
      end
      default: begin
        if (go && !finish) begin
          clear_work = 1'b1;
          take       = valid;
          state_next = ST_RUN;
        end else if (finish) begin
          state_next = ST_ERROR;
        end
      end
    endcase
  end

  // Working-register update. Starting a sequence clears the working set
  // before the first sample is folded in, so the start cycle and RUN
  // cycles share one accumulate path.
  always_comb begin
    base_min = clear_work ? '0 : cur_min;
    base_max = clear_work ? '0 : cur_max;
    base_cnt = clear_work ? '0 : cur_cnt;
    base_sat = clear_work ? 1'b0 : cur_sat;

    nxt_min = base_min;
    nxt_max = base_max;
    nxt_cnt = base_cnt;
    nxt_sat = base_sat;
    if (take) begin
      if (base_cnt == '0) begin
        nxt_min = data_in;
        nxt_max = data_in;
      end else begin
        if (is_less(data_in, base_min)) nxt_min = data_in;
        if (is_less(base_max, data_in)) nxt_max = data_in;
      end
      if (base_cnt != CNT_MAX) nxt_cnt = base_cnt + 1'b1;
      if (nxt_cnt == CNT_MAX) nxt_sat = 1'b1;
    end
    nxt_range = extend(nxt_max) - extend(nxt_min);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      cur_min   <= '0;
      cur_max   <= '0;
      cur_cnt   <= '0;
      cur_sat   <= 1'b0;
      min_val   <= '0;
      max_val   <= '0;
      range     <= '0;
      count     <= '0;
      count_sat <= 1'b0;
      done      <= 1'b0;
    end else begin
      state   <= state_next;
      cur_min <= nxt_min;
      cur_max <= nxt_max;
      cur_cnt <= nxt_cnt;
      cur_sat <= nxt_sat;
      done    <= complete;
      if (complete) begin
        min_val   <= nxt_min;
        max_val   <= nxt_max;
        range     <= nxt_range;
        count     <= nxt_cnt;
        count_sat <= nxt_sat;
      end
    end
  end

  assign busy  = (state == ST_RUN);
  assign error = (state == ST_ERROR);

endmodule

// File: tb/tb_range_finder_stream.sv
module tb_range_finder_stream;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset;
  logic [W-1:0]  data_in;
  logic          valid, go, finish;
  logic [W-1:0]  min_val, max_val;
  logic [W:0]    range;
  logic [CW-1:0] count;
  logic          count_sat, done, busy, error;

  range_finder_stream #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset), .data_in(data_in), .valid(valid),
    .go(go), .finish(finish), .min_val(min_val), .max_val(max_val),
    .range(range), .count(count), .count_sat(count_sat), .done(done),
    .busy(busy), .error(error)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: sequence as a queue of accepted samples, results
  // computed from the queue on completion.
  int   q[$];
  bit   in_seq, in_err;
  int   m_min, m_max, m_range, m_cnt, m_sat, m_done;

  function automatic int as_num(input logic [W-1:0] x);
`ifdef RANGE_FINDER_SIGNED_EN
    return int'($signed(x));
`else
    return int'(x);
`endif
  endfunction

  task automatic model(input bit r, input bit g, input bit f, input bit v,
                       input logic [W-1:0] d);
    m_done = 0;
    if (r) begin
      q.delete(); in_seq = 0; in_err = 0;
      m_min = 0; m_max = 0; m_range = 0; m_cnt = 0; m_sat = 0;
    end else if (!in_seq) begin
      if (g && !f) begin
        q.delete();
        if (v) q.push_back(int'(d));
        in_seq = 1; in_err = 0;
      end else if (f) begin
        in_err = 1;
      end
    end else begin
      if (g) begin
        in_seq = 0; in_err = 1;
      end else if (f) begin
        if (v) q.push_back(int'(d));
        in_seq = 0;
        if (q.size() == 0) begin
          in_err = 1;
        end else begin
          int lo, hi;
          lo = q[0]; hi = q[0];
          foreach (q[i]) begin
            if (as_num(q[i][W-1:0]) < as_num(lo[W-1:0])) lo = q[i];
            if (as_num(q[i][W-1:0]) > as_num(hi[W-1:0])) hi = q[i];
          end
          m_min   = lo;
          m_max   = hi;
          m_range = as_num(hi[W-1:0]) - as_num(lo[W-1:0]);
          m_cnt   = (q.size() > CMAX) ? CMAX : q.size();
          m_sat   = (q.size() >= CMAX) ? 1 : 0;
          m_done  = 1;
        end
      end else if (v) begin
        q.push_back(int'(d));
      end
    end
  endtask

  task automatic step(input bit r, input bit g, input bit f, input bit v,
                      input logic [W-1:0] d);
    reset = r; go = g; finish = f; valid = v; data_in = d;
    @(posedge clock);
    model(r, g, f, v, d);
    #1;
    check("min_val",   32'(min_val),   32'(m_min));
    check("max_val",   32'(max_val),   32'(m_max));
    check("range",     32'(range),     32'(m_range));
    check("count",     32'(count),     32'(m_cnt));
    check("count_sat", 32'(count_sat), 32'(m_sat));
    check("done",      32'(done),      32'(m_done));
    check("busy",      32'(busy),      32'(in_seq));
    check("error",     32'(error),     32'(in_err));
  endtask

  initial begin
    int fin_pct;
    bit g, f, v, r;
    logic [W-1:0] d;

    // Reset state.
    step(1, 0, 0, 0, 8'd0);
    step(1, 0, 0, 0, 8'd0);
    check("rst_busy", 32'(busy), 0);

    // Basic sequence.
    step(0, 1, 0, 1, 8'd10);
    step(0, 0, 0, 1, 8'd200);
    step(0, 0, 0, 1, 8'd3);
    step(0, 0, 0, 1, 8'd50);
    step(0, 0, 1, 1, 8'd7);
`ifndef RANGE_FINDER_SIGNED_EN
    check("basic_min",   32'(min_val), 3);
    check("basic_max",   32'(max_val), 200);
    check("basic_range", 32'(range),   197);
    check("basic_count", 32'(count),   5);
    check("basic_done",  32'(done),    1);
`endif
    step(0, 0, 0, 0, 8'd0);
    check("done_width", 32'(done), 0);

    // Error and recovery.
    step(0, 0, 1, 0, 8'd0);
    check("err_idle", 32'(error), 1);
    step(0, 1, 0, 1, 8'd5);
    step(0, 0, 1, 1, 8'd5);
    check("recover_range", 32'(range), 0);
    check("recover_count", 32'(count), 2);

    // Invalid cycles.
    step(0, 1, 0, 0, 8'd0);
    step(0, 0, 0, 0, 8'd255);
    step(0, 0, 0, 1, 8'd40);
    step(0, 0, 0, 1, 8'd90);
    step(0, 0, 1, 0, 8'd0);
    check("inv_min", 32'(min_val), 40);
    check("inv_max", 32'(max_val), 90);
    // Empty sequence.
    step(0, 1, 0, 0, 8'd0);
    step(0, 0, 1, 0, 8'd0);
    check("empty_err", 32'(error), 1);

    // Saturation, back-to-back start on the done cycle.
    step(0, 1, 0, 1, 8'd1);
    for (int i = 0; i < 18; i++) step(0, 0, 0, 1, 8'($urandom_range(0, 255)));
    step(0, 0, 1, 1, 8'd2);
    check("sat_count", 32'(count), CMAX);
    check("sat_flag",  32'(count_sat), 1);
    step(0, 1, 0, 1, 8'd9);
    step(0, 0, 0, 1, 8'd11);
    step(0, 1, 1, 1, 8'd12);   // restart mid-sequence
    check("restart_err", 32'(error), 1);

    // Reset mid-run.
    step(0, 1, 0, 1, 8'd4);
    step(0, 0, 0, 1, 8'd6);
    step(0, 0, 0, 1, 8'd8);
    step(1, 0, 0, 1, 8'd3);
    check("rst_mid_cnt", 32'(count), 0);
    step(0, 0, 1, 0, 8'd0);
    check("rst_then_fin", 32'(error), 1);

    // Signed vs unsigned ordering.
    step(0, 1, 0, 1, 8'h80);
    step(0, 0, 1, 1, 8'h7F);
`ifdef RANGE_FINDER_SIGNED_EN
    check("sgn_min",   32'(min_val), 32'h80);
    check("sgn_max",   32'(max_val), 32'h7F);
    check("sgn_range", 32'(range),   255);
`else
    check("uns_min",   32'(min_val), 32'h7F);
    check("uns_max",   32'(max_val), 32'h80);
    check("uns_range", 32'(range),   1);
`endif

    // Randomised traffic.
    fin_pct = 10;
    for (int n = 0; n < 1500; n++) begin
      r = ($urandom_range(0, 199) == 0);
      if (in_seq) begin
        g = ($urandom_range(0, 59) == 0);
        f = ($urandom_range(0, 99) < fin_pct);
      end else begin
        g = ($urandom_range(0, 2) == 0);
        f = ($urandom_range(0, 24) == 0);
        if (g) fin_pct = $urandom_range(3, 30);
      end
      v = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 5))
        0:       d = 8'h00;
        1:       d = 8'hFF;
        2:       d = 8'h80;
        3:       d = 8'h7F;
        default: d = 8'($urandom_range(0, 255));
      endcase
      step(r, g, f, v, d);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
